// File: rtl/gpio_pad_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_engine_if
// Description : Bundle of register-file controls, pad inputs and pad-side
//               outputs for the GPIO pad engine.
//               master : register file / bench side (drives controls, pads)
//               slave  : gpio_pad_engine side (drives io_out, io_en,
//                        in_val, ints, irq)
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_pad_engine_if #(
    parameter int W = 32
);
    logic [W-1:0] out_val;        // RGPIO_OUT value
    logic [W-1:0] oe;             // RGPIO_OE, 1 = bit drives pad
    logic [W-1:0] inte;           // per-bit interrupt enable
    logic [W-1:0] ptrig;          // 1 = rising, 0 = falling trigger
    logic [W-1:0] eclk;           // 1 = sample on ext clock edge
    logic [W-1:0] nec;            // ext clock edge: 0 = rising, 1 = falling
    logic         ien;            // global interrupt enable
    logic [W-1:0] ints_clr;       // write-1-to-clear pulses
    logic [W-1:0] io_pad_i;       // resolved pad value
    logic         ext_clk_pad_i;  // external sampling clock pad
    logic [W-1:0] io_out;         // pad output data
    logic [W-1:0] io_en;          // pad output enable
    logic [W-1:0] in_val;         // sampled input (RGPIO_IN)
    logic [W-1:0] ints;           // sticky interrupt status
    logic         irq;            // interrupt request

    modport master (
        output out_val, oe, inte, ptrig, eclk, nec, ien, ints_clr,
               io_pad_i, ext_clk_pad_i,
        input  io_out, io_en, in_val, ints, irq
    );

    modport slave (
        input  out_val, oe, inte, ptrig, eclk, nec, ien, ints_clr,
               io_pad_i, ext_clk_pad_i,
        output io_out, io_en, in_val, ints, irq
    );
endinterface
`default_nettype wire

// File: rtl/gpio_pad_engine.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_engine
// Description : Pad-side engine of the APB GPIO core. Registers output data
//               and enables toward the pad tri-states, synchronises pad
//               inputs, samples them on PCLK or on a selected edge of the
//               external clock pad, detects programmable edges and keeps
//               sticky per-bit interrupt status with a combined irq.
// Ports       : PCLK   - system clock, all flops on rising edge
//               PRESET - asynchronous reset, active-high
//               bus    - gpio_pad_engine_if.slave (controls, pads, status)
// Options     : GPIO_IN_DEGLITCH_EN - adds a two-sample agreement filter
//               after the input synchroniser (single-cycle pulses rejected,
//               PCLK-mode latency 4 edges instead of 3).
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_engine #(
    parameter int W = 32
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    gpio_pad_engine_if.slave     bus
);

    logic [W-1:0] io_out_q, io_en_q;
    logic [W-1:0] s1_q, s2_q;
    logic         e1_q, e2_q, e3_q;
    logic [W-1:0] in_val_q, in_val_d;
    logic [W-1:0] prev_q;
    logic [W-1:0] ints_q, ints_d;
    logic         irq_q, irq_d;
    logic [W-1:0] samp;
    logic [W-1:0] upd;
    logic [W-1:0] ev;
    logic         ext_rise, ext_fall;

`ifdef GPIO_IN_DEGLITCH_EN
    logic [W-1:0] f_q, f_d;

    // s1 and s2 hold two consecutive pad samples; the filter only follows
    // the pad once both agree, so a one-sample pulse never reaches f.
    always_comb begin
        f_d = (~(s1_q ^ s2_q) & s2_q) | ((s1_q ^ s2_q) & f_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign samp = f_q;
`else
    assign samp = s2_q;
`endif

    // e3 is one cycle older than e2, so these are single-cycle strobes.
    assign ext_rise = e2_q & ~e3_q;
    assign ext_fall = ~e2_q & e3_q;

    always_comb begin
        // PCLK-mode bits always update; ext-clock bits only on their edge.
        upd      = ~bus.eclk
                 | ( bus.nec & {W{ext_fall}})
                 | (~bus.nec & {W{ext_rise}});
        in_val_d = (upd & samp) | (~upd & in_val_q);
        ev       = ( bus.ptrig &  in_val_q & ~prev_q)
                 | (~bus.ptrig & ~in_val_q &  prev_q);
        // Set term OR'd last so a simultaneous event beats the clear.
        ints_d   = (ints_q & ~bus.ints_clr) | (ev & bus.inte);
        irq_d    = bus.ien & (|ints_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            io_out_q <= '0;
            io_en_q  <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            e1_q     <= 1'b0;
            e2_q     <= 1'b0;
            e3_q     <= 1'b0;
            in_val_q <= '0;
            prev_q   <= '0;
            ints_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            io_out_q <= bus.out_val;
            io_en_q  <= bus.oe;
            s1_q     <= bus.io_pad_i;
            s2_q     <= s1_q;
            e1_q     <= bus.ext_clk_pad_i;
            e2_q     <= e1_q;
            e3_q     <= e2_q;
            in_val_q <= in_val_d;
            prev_q   <= in_val_q;
            ints_q   <= ints_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.io_out = io_out_q;
    assign bus.io_en  = io_en_q;
    assign bus.in_val = in_val_q;
    assign bus.ints   = ints_q;
    assign bus.irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pad_engine
// Description : Self-checking bench for gpio_pad_engine: table-driven output
//               path vectors, hand sequences for latency/edge/status corner
//               cases, and a randomized run against a history-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_engine;
    localparam int W  = 32;
    localparam int NR = 300;
`ifdef GPIO_IN_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    gpio_pad_engine_if #(.W(W)) bus ();

    gpio_pad_engine #(.W(W)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ov;
        logic [W-1:0] oe;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_en;
    } vec_t;

    vec_t tbl [4];

    // Model histories: index k is the state after edge k of the random run;
    // indices 0..3 represent the all-zero state right after reset.
    logic [W-1:0] P    [0:NR+3];
    logic         E    [0:NR+3];
    logic [W-1:0] FM   [0:NR+3];
    logic [W-1:0] IN   [0:NR+3];
    logic [W-1:0] INTS [0:NR+3];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [W-1:0] pad;
        logic [W-1:0] src, ev, rnd_eclk, rnd_nec;
        logic         rise, fall, ienv;

        tbl[0] = '{32'hA5A5_0F0F, 32'hFFFF_0000, 32'hA5A5_0F0F, 32'hFFFF_0000};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[3] = '{32'h1234_5678, 32'h0F0F_0F0F, 32'h1234_5678, 32'h0F0F_0F0F};

        rst = 1'b1;
        bus.out_val = '0; bus.oe = '0; bus.inte = '0; bus.ptrig = '0;
        bus.eclk = '0; bus.nec = '0; bus.ien = 1'b0; bus.ints_clr = '0;
        bus.io_pad_i = '0; bus.ext_clk_pad_i = 1'b0;
        tick(2);
        chk("rst_io_out", bus.io_out, '0);
        chk("rst_io_en",  bus.io_en,  '0);
        chk("rst_in_val", bus.in_val, '0);
        chk("rst_ints",   bus.ints,   '0);
        chk("rst_irq",    {31'b0, bus.irq}, '0);
        rst = 1'b0;

        // ---------------- output path table ----------------
        for (int i = 0; i < 4; i++) begin
            bus.out_val = tbl[i].ov;
            bus.oe      = tbl[i].oe;
            tick(1);
            chk("tbl_io_out", bus.io_out, tbl[i].exp_out);
            chk("tbl_io_en",  bus.io_en,  tbl[i].exp_en);
        end
        // asynchronous reset mid-run clears immediately
        rst = 1'b1;
        #1;
        chk("midrst_io_out", bus.io_out, '0);
        chk("midrst_io_en",  bus.io_en,  '0);
        rst = 1'b0;
        bus.out_val = '0; bus.oe = '0;
        tick(2);

        // ---------------- PCLK sampling latency, ints, irq ----------------
        bus.ptrig = 32'h8; bus.inte = 32'h8; bus.ien = 1'b1;
        tick(4);
        bus.io_pad_i = 32'h8;
        tick(LAT - 1);
        chk("lat_before", bus.in_val & 32'h8, 32'h0);
        tick(1);
        chk("lat_at", bus.in_val & 32'h8, 32'h8);
        tick(1);
        chk("ints3_set", bus.ints, 32'h8);
        chk("irq_not_yet", {31'b0, bus.irq}, '0);
        tick(1);
        chk("irq_set", {31'b0, bus.irq}, 32'h1);

        // ---------------- ext clock sampling ----------------
        bus.ints_clr = '1; bus.inte = '0; bus.ien = 1'b0;
        tick(1);
        bus.ints_clr = '0;
        bus.eclk = 32'hFF; bus.nec = '0; bus.io_pad_i = 32'h3C;
        tick(4);
        chk("ext_hold", bus.in_val & 32'hFF, 32'h08);
        bus.ext_clk_pad_i = 1'b1;
        tick(2);
        chk("ext_early", bus.in_val & 32'hFF, 32'h08);
        tick(2);
        chk("ext_rise", bus.in_val & 32'hFF, 32'h3C);
        bus.ext_clk_pad_i = 1'b0;
        tick(4);
        bus.io_pad_i = 32'h3D; bus.nec = 32'h1; bus.ext_clk_pad_i = 1'b1;
        tick(5);
        chk("nec_rise_ignored", bus.in_val & 32'hFF, 32'h3C);
        bus.ext_clk_pad_i = 1'b0;
        tick(4);
        chk("nec_fall", bus.in_val & 32'hFF, 32'h3D);

        // ---------------- set-wins-over-clear on bit 5 ----------------
        bus.eclk = '0; bus.nec = '0; bus.ptrig = '0; bus.inte = 32'h20; bus.ien = 1'b1;
        tick(2);
        bus.io_pad_i = 32'h1D;
        tick(LAT + 1);
        chk("b5_set", bus.ints, 32'h20);
        bus.io_pad_i = 32'h3D;
        tick(6);
        chk("b5_rise_noclr", bus.ints, 32'h20);
        chk("b5_irq", {31'b0, bus.irq}, 32'h1);
        bus.io_pad_i = 32'h1D;
        tick(LAT);
        bus.ints_clr = 32'h20;
        tick(1);
        bus.ints_clr = '0;
        chk("b5_set_wins", bus.ints, 32'h20);
        bus.ints_clr = 32'h20;
        tick(1);
        bus.ints_clr = '0;
        chk("b5_cleared", bus.ints, 32'h0);
        tick(1);
        chk("b5_irq_low", {31'b0, bus.irq}, '0);

        // ---------------- single/multi-cycle pulses on bit 9 ----------------
        bus.ptrig = 32'h200; bus.inte = 32'h200;
        tick(2);
        bus.io_pad_i = 32'h21D;
        tick(1);
        bus.io_pad_i = 32'h1D;
`ifdef GPIO_IN_DEGLITCH_EN
        tick(6);
        chk("b9_glitch_in", bus.in_val & 32'h200, 32'h0);
        chk("b9_glitch_ints", bus.ints, 32'h0);
        bus.io_pad_i = 32'h21D;
        tick(3);
        chk("b9_pulse_early", bus.in_val & 32'h200, 32'h0);
        bus.io_pad_i = 32'h1D;
        tick(1);
        chk("b9_pulse_in", bus.in_val & 32'h200, 32'h200);
`else
        tick(2);
        chk("b9_pulse_in", bus.in_val & 32'h200, 32'h200);
        tick(1);
        chk("b9_pulse_out", bus.in_val & 32'h200, 32'h0);
        chk("b9_pulse_ints", bus.ints, 32'h200);
`endif
        tick(6);

        // ---------------- randomized run against history model ----------------
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int j = 0; j <= 3; j++) begin
            P[j] = '0; E[j] = 1'b0; FM[j] = '0; IN[j] = '0; INTS[j] = '0;
        end
        pad = '0; rnd_eclk = '0; rnd_nec = '0; ienv = 1'b0;
        for (int k = 4; k <= NR + 3; k++) begin
            if ((k % 40) == 4) begin
                rnd_eclk = $urandom;
                rnd_nec  = $urandom;
                ienv     = $urandom_range(0, 1) == 1;
            end
            pad = pad ^ ($urandom & $urandom);
            bus.io_pad_i = pad;
            if ($urandom_range(0, 2) == 0) bus.ext_clk_pad_i = ~bus.ext_clk_pad_i;
            bus.out_val  = $urandom;
            bus.oe       = $urandom;
            bus.eclk     = rnd_eclk;
            bus.nec      = rnd_nec;
            bus.ptrig    = $urandom;
            bus.inte     = $urandom;
            bus.ien      = ienv;
            bus.ints_clr = $urandom & $urandom & $urandom;
            P[k] = pad;
            E[k] = bus.ext_clk_pad_i;
            tick(1);

            rise = E[k-2] & ~E[k-3];
            fall = ~E[k-2] & E[k-3];
            for (int b = 0; b < W; b++)
                FM[k][b] = (P[k-1][b] == P[k-2][b]) ? P[k-2][b] : FM[k-1][b];
`ifdef GPIO_IN_DEGLITCH_EN
            src = FM[k-1];
`else
            src = P[k-2];
`endif
            for (int b = 0; b < W; b++) begin
                if (!bus.eclk[b] || (bus.nec[b] ? fall : rise))
                    IN[k][b] = src[b];
                else
                    IN[k][b] = IN[k-1][b];
                ev[b] = bus.ptrig[b] ? (IN[k-1][b] && !IN[k-2][b])
                                     : (!IN[k-1][b] && IN[k-2][b]);
                if (ev[b] && bus.inte[b])
                    INTS[k][b] = 1'b1;
                else if (bus.ints_clr[b])
                    INTS[k][b] = 1'b0;
                else
                    INTS[k][b] = INTS[k-1][b];
            end
            chk("rnd_io_out", bus.io_out, bus.out_val);
            chk("rnd_io_en",  bus.io_en,  bus.oe);
            chk("rnd_in_val", bus.in_val, IN[k]);
            chk("rnd_ints",   bus.ints,   INTS[k]);
            chk("rnd_irq", {31'b0, bus.irq}, {31'b0, (ienv && (INTS[k-1] != '0))});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gpio_pad_engine.md
Name: gpio_pad_engine

Overview:
- Pad-side engine of the APB GPIO core; the DUT end of the bench's bidirectional pad bus (io_pad, ext_clk_pad_i).
- Registers output data and per-bit output enables toward the pad tri-states.
- Synchronises and samples pad inputs, either on PCLK or on a selected edge of ext_clk_pad_i.
- Detects programmable input edges and raises sticky per-bit interrupt status with a combined irq.

Parameters:
- W, 32, number of GPIO bits (matches io_pad width)

Ports:
- PCLK  input  1  system clock; all flops on posedge
- PRESET  input  1  asynchronous reset, active-high
- out_val  input  W  RGPIO_OUT value from register file
- oe  input  W  RGPIO_OE; 1 = bit drives pad
- inte  input  W  per-bit interrupt enable
- ptrig  input  W  per-bit trigger: 1 = rising, 0 = falling edge of in_val
- eclk  input  W  per-bit input sampling: 1 = ext_clk_pad_i edge, 0 = PCLK
- nec  input  W  ext clock edge select: 0 = rising, 1 = falling
- ien  input  1  global interrupt enable
- ints_clr  input  W  one-cycle write-1-to-clear pulses for ints
- io_pad_i  input  W  pad input (resolved pad value)
- ext_clk_pad_i  input  1  external sampling clock pad, asynchronous to PCLK
- io_out  output  W  pad output data
- io_en  output  W  pad output enable; pad is hi-Z where 0
- in_val  output  W  sampled input value (RGPIO_IN)
- ints  output  W  sticky interrupt status
- irq  output  1  interrupt request

Behaviour:
- Reset (async, PRESET=1): io_out, io_en, in_val, ints, irq, all synchroniser and edge flops = 0. Deassertion takes effect at the next PCLK edge.
- Reset mid-operation: all state is cleared immediately, including pending edges and sticky status.
- Output path:
  - io_out <= out_val and io_en <= oe every cycle; latency 1 PCLK.
  - No glitch-free ordering between io_en and io_out is required; both update on the same edge.
- Input sync:
  - io_pad_i passes through two flops (s1, s2).
  - ext_clk_pad_i passes through three flops (e1, e2, e3).
  - ext_rise = e2 & ~e3; ext_fall = ~e2 & e3.
- Sampling, per bit i:
  - eclk[i]=0: in_val[i] <= s2[i] every cycle. Pad-to-in_val latency = 3 PCLK edges.
  - eclk[i]=1: in_val[i] <= s2[i] only when (nec[i] ? ext_fall : ext_rise); otherwise it holds.
  - Changing eclk or nec takes effect on the next cycle; no spurious update is generated by the change itself.
- Edge detect: prev_in <= in_val every cycle.
  - ev[i] = ptrig[i] ? (in_val[i] & ~prev_in[i]) : (~in_val[i] & prev_in[i]).
- Status: ints[i] <= (ints[i] & ~ints_clr[i]) | (ev[i] & inte[i]).
  - Simultaneous set and clear: set wins; ints stays 1.
  - inte=0 masks new events but does not clear existing status.
- irq <= ien & |ints (registered, 1 cycle after ints).
- Wrap/saturation: none; status bits are saturating flags.
- Loopback: a bit with io_en=1 reads back its own io_out via io_pad_i through the normal input path.

Optional Feature:
- Macro: GPIO_IN_DEGLITCH_EN.
- Defined:
  - Add a filter stage after s2: f[i] updates to s2[i] only when s2[i] equals the previous s2 sample for 2 consecutive cycles.
  - in_val samples f instead of s2. PCLK-mode latency becomes 4 edges.
  - Single-cycle pad pulses are rejected.
- Undefined: no filter; behaviour exactly as above.

Test Plan:
- Reset, then out_val=32'hA5A5_0F0F, oe=32'hFFFF_0000 -> io_out=A5A5_0F0F and io_en=FFFF_0000 one PCLK later. Assert PRESET mid-run -> both 0 immediately.
- eclk=0, io_pad_i bit3 0->1 -> in_val[3]=1 on the 3rd PCLK edge. With ptrig[3]=1, inte[3]=1, ien=1 -> ints[3]=1 next cycle, irq=1 one cycle later.
- eclk=32'hFF, nec=0, io_pad_i=8'h3C held, then 4 PCLK cycles with no ext clock edge -> in_val[7:0] unchanged. Ext clock rises -> in_val[7:0]=8'h3C within 4 PCLK.
- nec[0]=1, ext_clk_pad_i rising only -> no update. Then falling -> in_val[0] updates.
- ints[5]=1; ints_clr[5] pulses in the same cycle as a new falling event on bit5 with ptrig[5]=0 -> ints[5] stays 1. Clear with no event -> ints[5]=0, irq=0 one cycle later.
- With GPIO_IN_DEGLITCH_EN: 1-cycle pulse on io_pad_i[9] -> in_val[9] unchanged, no ints. 3-cycle pulse -> in_val[9] toggles, latency 4.
